// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes,
// opcodes and datapath mux selects, also used by the PC-write controller.
package mips_ctrl_pkg;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX_R   = 4'd2,
        S_WB_R   = 4'd3,
        S_EX_I   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_BRANCH = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_LD  = 4'd9,
        S_JUMP   = 4'd10,
        S_WB_I   = 4'd11,
        S_HALT   = 4'd14,
        S_ERR    = 4'd15
    } state_e;

    localparam logic [5:0] OP_R        = 6'b000000;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_ADDI     = 6'b000100;
    localparam logic [5:0] OP_ANDI     = 6'b000101;
    localparam logic [5:0] OP_LW       = 6'b000110;
    localparam logic [5:0] OP_SW       = 6'b000111;
    localparam logic [5:0] OP_BGT      = 6'b001000;
    localparam logic [5:0] OP_BLT      = 6'b001001;
    localparam logic [5:0] OP_BEQ      = 6'b001010;
    localparam logic [5:0] OP_BNE      = 6'b001011;
    localparam logic [5:0] OP_HALT_DEF = 6'b111111;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_IMM   = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_4    = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_IMMS = 2'd3;

    localparam logic [1:0] DST_RT    = 2'd0;
    localparam logic [1:0] DST_RD    = 2'd1;
    localparam logic [1:0] DST_R31   = 2'd2;

    // Successor of ID; halt is tested first so it wins any opcode overlap.
    function automatic state_e id_next(logic [5:0] op, logic [5:0] halt_op);
        state_e nxt;
        if (op == halt_op) begin
            nxt = S_HALT;
        end else begin
            case (op)
                OP_R:                      nxt = S_EX_R;
                OP_ADDI, OP_ANDI:          nxt = S_EX_I;
                OP_LW, OP_SW:              nxt = S_ADDR;
                OP_BGT, OP_BLT,
                OP_BEQ, OP_BNE:            nxt = S_BRANCH;
                OP_J, OP_JAL:              nxt = S_JUMP;
                default:                   nxt = S_ERR;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// Pure state -> datapath control ROM for the multicycle sequencer.
// is_jal_i only refines the JUMP state (link write to r31).
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       is_jal_i,
    output logic       pc_write_uncond_o,
    output logic       ir_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] pc_src_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       illegal_op_o
);

    always_comb begin
        pc_write_uncond_o = 1'b0;
        ir_write_o        = 1'b0;
        mem_read_o        = 1'b0;
        mem_write_o       = 1'b0;
        reg_write_o       = 1'b0;
        pc_src_o          = PC_ALU;
        alu_src_a_o       = 1'b0;
        alu_src_b_o       = SRCB_REG;
        alu_op_o          = ALU_ADD;
        reg_dst_o         = DST_RT;
        mem_to_reg_o      = 1'b0;
        illegal_op_o      = 1'b0;
        unique case (state_i)
            S_IF: begin
                mem_read_o        = 1'b1;
                ir_write_o        = 1'b1;
                pc_write_uncond_o = 1'b1;
                alu_src_b_o       = SRCB_4;
            end
            S_ID: begin
                alu_src_b_o = SRCB_IMMS;
            end
            S_EX_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            S_WB_R: begin
                reg_write_o = 1'b1;
                reg_dst_o   = DST_RD;
            end
            S_EX_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_IMM;
            end
            S_WB_I: begin
                reg_write_o = 1'b1;
            end
            S_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
            end
            S_WB_LD: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            // PC write here is left to the flag-driven PC-write controller.
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_SUB;
                pc_src_o    = PC_BRANCH;
            end
            S_JUMP: begin
                pc_write_uncond_o = 1'b1;
                pc_src_o          = PC_JUMP;
                if (is_jal_i) begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = DST_R31;
                end
            end
            S_ERR: begin
                illegal_op_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle MIPS datapath.
// Optional memory handshake stalls are enabled by defining MEM_WAIT_EN.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = OP_HALT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic       pcWriteUncond,
    output logic       irWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic [1:0] pcSrc,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] regDst,
    output logic       memToReg,
    output logic       illegal_op
);

    state_e state_q, state_d;
    logic   jal_q, jal_d;
    logic   mem_ok;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        jal_d   = jal_q;
        case (state_q)
            S_IF:     state_d = mem_ok ? S_ID : S_IF;
            S_ID: begin
                state_d = id_next(opcode, HALT_OP);
                jal_d   = (opcode == OP_JAL);
            end
            S_EX_R:   state_d = S_WB_R;
            S_EX_I:   state_d = S_WB_I;
            S_ADDR:   state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: state_d = mem_ok ? S_WB_LD : S_MEM_RD;
            S_MEM_WR: state_d = mem_ok ? S_IF : S_MEM_WR;
            S_WB_R, S_WB_I, S_WB_LD,
            S_BRANCH, S_JUMP:
                      state_d = S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            jal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            jal_q   <= jal_d;
        end
    end

    logic       d_pcwu, d_irw, d_mrd, d_mwr, d_rw;
    logic       d_srca, d_m2r, d_ill;
    logic [1:0] d_pcsrc, d_srcb, d_aluop, d_regdst;

    ctrl_output_decode u_decode (
        .state_i           (state_q),
        .is_jal_i          (jal_q),
        .pc_write_uncond_o (d_pcwu),
        .ir_write_o        (d_irw),
        .mem_read_o        (d_mrd),
        .mem_write_o       (d_mwr),
        .reg_write_o       (d_rw),
        .pc_src_o          (d_pcsrc),
        .alu_src_a_o       (d_srca),
        .alu_src_b_o       (d_srcb),
        .alu_op_o          (d_aluop),
        .reg_dst_o         (d_regdst),
        .mem_to_reg_o      (d_m2r),
        .illegal_op_o      (d_ill)
    );

    // A stalled fetch must not latch IR or bump PC more than once.
    logic fetch_ok;
    logic live;
    assign fetch_ok = (state_q != S_IF) | mem_ok;
    assign live     = ~reset;

    assign state         = state_q;
    assign pcWriteUncond = live & d_pcwu & fetch_ok;
    assign irWrite       = live & d_irw & fetch_ok;
    assign memRead       = live & d_mrd;
    assign memWrite      = live & d_mwr;
    assign regWrite      = live & d_rw;
    assign pcSrc         = {2{live}} & d_pcsrc;
    assign aluSrcA       = live & d_srca;
    assign aluSrcB       = {2{live}} & d_srcb;
    assign aluOp         = {2{live}} & d_aluop;
    assign regDst        = {2{live}} & d_regdst;
    assign memToReg      = live & d_m2r;
    assign illegal_op    = live & d_ill;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: instruction table plus
// hand-written reset, error, halt and memory-stall sequences.
module tb_multicycle_control_fsm;
    import mips_ctrl_pkg::*;

`ifdef MEM_WAIT_EN
    localparam bit MW = 1'b1;
`else
    localparam bit MW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [3:0] state;
    logic       pcWriteUncond, irWrite, memRead, memWrite, regWrite;
    logic [1:0] pcSrc, aluSrcB, aluOp, regDst;
    logic       aluSrcA, memToReg, illegal_op;

    multicycle_control_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .state         (state),
        .pcWriteUncond (pcWriteUncond),
        .irWrite       (irWrite),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .regWrite      (regWrite),
        .pcSrc         (pcSrc),
        .aluSrcA       (aluSrcA),
        .aluSrcB       (aluSrcB),
        .aluOp         (aluOp),
        .regDst        (regDst),
        .memToReg      (memToReg),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] out;
    } exp_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        int          len;
        logic [23:0] seq;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Order: pcWU irW mRd mWr rW pcSrc[2] srcA srcB[2] aluOp[2] dst[2] m2r ill
    function automatic logic [15:0] model(logic [3:0] st, logic [5:0] op,
                                          logic mr, logic rst);
        logic pcwu, irw, mrd, mwr, rw, a, m2r, ill;
        logic [1:0] ps, b, ao, rd;
        {pcwu, irw, mrd, mwr, rw, a, m2r, ill} = '0;
        {ps, b, ao, rd} = '0;
        if (!rst) begin
            case (st)
                4'd0: begin
                    mrd = 1'b1; b = 2'd1;
                    irw = MW ? mr : 1'b1;
                    pcwu = irw;
                end
                4'd1: b = 2'd3;
                4'd2: begin a = 1'b1; ao = 2'd2; end
                4'd3: begin rw = 1'b1; rd = 2'd1; end
                4'd4: begin a = 1'b1; b = 2'd2; ao = 2'd3; end
                4'd11: rw = 1'b1;
                4'd5: begin a = 1'b1; b = 2'd2; end
                4'd6: mrd = 1'b1;
                4'd8: mwr = 1'b1;
                4'd9: begin rw = 1'b1; m2r = 1'b1; end
                4'd7: begin a = 1'b1; ao = 2'd1; ps = 2'd1; end
                4'd10: begin
                    pcwu = 1'b1; ps = 2'd2;
                    if (op == 6'b000011) begin rw = 1'b1; rd = 2'd2; end
                end
                4'd15: ill = 1'b1;
                default: ;
            endcase
        end
        return {pcwu, irw, mrd, mwr, rw, ps, a, b, ao, rd, m2r, ill};
    endfunction

    task automatic sample(input string nm, input logic [3:0] st);
        exp_t e;
        logic [15:0] got;
        sb.push_back('{st, model(st, opcode, mem_ready, reset)});
        #1;
        e = sb.pop_front();
        got = {pcWriteUncond, irWrite, memRead, memWrite, regWrite, pcSrc,
               aluSrcA, aluSrcB, aluOp, regDst, memToReg, illegal_op};
        checks++;
        if (state !== e.st) begin
            errors++;
            $display("FAIL %s state got %0d want %0d", nm, state, e.st);
        end
        checks++;
        if (got !== e.out) begin
            errors++;
            $display("FAIL %s outs st=%0d got %h want %h", nm, e.st, got, e.out);
        end
        checks++;
        if ((memRead & memWrite) || (state == 4'd7 && pcWriteUncond)) begin
            errors++;
            $display("FAIL %s invariant st=%0d mr=%b mw=%b pcwu=%b",
                     nm, state, memRead, memWrite, pcWriteUncond);
        end
    endtask

    task automatic step(input string nm, input logic [3:0] st);
        sample(nm, st);
        @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        step(nm, 4'd0);
        step(nm, 4'd0);
        reset = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{"rtype", 6'b000000, 4, 24'h003210};
        vecs[1]  = '{"lw",    6'b000110, 5, 24'h096510};
        vecs[2]  = '{"sw",    6'b000111, 4, 24'h008510};
        vecs[3]  = '{"addi",  6'b000100, 4, 24'h00B410};
        vecs[4]  = '{"andi",  6'b000101, 4, 24'h00B410};
        vecs[5]  = '{"beq",   6'b001010, 3, 24'h000710};
        vecs[6]  = '{"bne",   6'b001011, 3, 24'h000710};
        vecs[7]  = '{"bgt",   6'b001000, 3, 24'h000710};
        vecs[8]  = '{"blt",   6'b001001, 3, 24'h000710};
        vecs[9]  = '{"j",     6'b000010, 3, 24'h000A10};
        vecs[10] = '{"jal",   6'b000011, 3, 24'h000A10};

        reset = 1'b1;
        opcode = 6'b000000;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step("reset_hold", 4'd0);
        reset = 1'b0;

        for (int v = 0; v < 11; v++) begin
            opcode = vecs[v].op;
            for (int k = 0; k < vecs[v].len; k++)
                step(vecs[v].name, vecs[v].seq[4*k +: 4]);
        end

        // Reset while in MEM_WR: strobe must drop asynchronously.
        opcode = 6'b000111;
        step("sw_rst", 4'd0);
        step("sw_rst", 4'd1);
        step("sw_rst", 4'd5);
        sample("sw_memwr", 4'd8);
        #2;
        reset = 1'b1;
        sample("rst_async", 4'd0);
        @(negedge clk);
        step("rst_hold", 4'd0);
        reset = 1'b0;
        opcode = 6'b000000;
        step("post_rst", 4'd0);
        step("post_rst", 4'd1);
        step("post_rst", 4'd2);
        step("post_rst", 4'd3);

        // Illegal opcode parks in ERR until reset.
        opcode = 6'b110000;
        step("err", 4'd0);
        step("err", 4'd1);
        for (int i = 0; i < 20; i++) step("err_hold", 4'd15);
        opcode = 6'b000000;
        step("err_opchg", 4'd15);
        do_reset("err_rst");

        opcode = 6'b111111;
        step("halt", 4'd0);
        step("halt", 4'd1);
        for (int i = 0; i < 5; i++) step("halt_hold", 4'd14);
        do_reset("halt_rst");

`ifdef MEM_WAIT_EN
        opcode = 6'b000110;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("if_wait", 4'd0);
        mem_ready = 1'b1;
        step("if_go", 4'd0);
        step("lw_w", 4'd1);
        step("lw_w", 4'd5);
        mem_ready = 1'b0;
        step("rd_wait", 4'd6);
        step("rd_wait", 4'd6);
        mem_ready = 1'b1;
        step("rd_go", 4'd6);
        step("lw_w", 4'd9);
        opcode = 6'b000111;
        step("sw_w", 4'd0);
        step("sw_w", 4'd1);
        step("sw_w", 4'd5);
        mem_ready = 1'b0;
        step("wr_wait", 4'd8);
        mem_ready = 1'b1;
        step("wr_go", 4'd8);
        step("sw_w", 4'd0);
`else
        opcode = 6'b000110;
        mem_ready = 1'b0;
        step("lw_nordy", 4'd0);
        step("lw_nordy", 4'd1);
        step("lw_nordy", 4'd5);
        step("lw_nordy", 4'd6);
        step("lw_nordy", 4'd9);
        step("lw_nordy", 4'd0);
        mem_ready = 1'b1;
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
